l2_ddr_port_ctrl: RTL

//  DDR-side port for the L2 cache; sits directly downstream of the L2 DDR port state machine.
//  - Grants the L2 bus.
//  - Converts L2 read/write requests into BURST_BEATS-beat 128-bit bursts on an MIG-style
//    app interface.
//  - Tracks the DDR fetch window (base/fetch pointers) from L2 base inc/dec pulses.
//  - Drives operate_lock and force_loading back to the L2.

---
 rtl/l2_ddr_port_ctrl_if.sv | 26 ++
 rtl/l2_ddr_port_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_ddr_port_ctrl_if.sv
// MIG-style app bus between the L2 DDR port controller (master) and the memory controller (slave).
interface l2_ddr_port_ctrl_if #(
  parameter int unsigned ADDR_W = 24
) ();
  logic              app_en;
  logic [2:0]        app_cmd;
  logic [ADDR_W+2:0] app_addr;
  logic              app_rdy;
  logic [127:0]      app_wdf_data;
  logic              app_wdf_wren;
  logic              app_wdf_end;
  logic              app_wdf_rdy;
  logic [127:0]      app_rd_data;
  logic              app_rd_data_valid;
  logic              init_calib_complete;

  modport master (
    output app_en, app_cmd, app_addr, app_wdf_data, app_wdf_wren, app_wdf_end,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, init_calib_complete
  );

  modport slave (
    input  app_en, app_cmd, app_addr, app_wdf_data, app_wdf_wren, app_wdf_end,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, init_calib_complete
  );
endinterface

// File: rtl/l2_ddr_port_ctrl.sv
// DDR-side port for the L2 cache: bus grant, burst conversion onto the MIG app bus, fetch window.
// Optional statistics counters are built when L2_DDR_PORT_STATS_EN is defined.
module l2_ddr_port_ctrl #(
  parameter int unsigned ADDR_W       = 24,
  parameter int unsigned BURST_BEATS  = 8,
  parameter int unsigned WINDOW_WORDS = 512
) (
  input  logic              clk_166M66,
  input  logic              mcu_sys_rst,
  input  logic              i_l2_ddr_operate_enable,
  input  logic              i_l2_ddr_rw,
  output logic              o_l2_ddr_bus_enable,
  output logic              o_l2_ddr_operate_lock,
  output logic              o_l2_ddr_force_loading,
  input  logic              i_ddr_base_addr_inc,
  input  logic              i_ddr_base_addr_dec,
  input  logic              i_jump_valid,
  input  logic [ADDR_W-1:0] i_jump_addr,
  output logic [127:0]      o_l2_rd_data,
  output logic              o_l2_rd_valid,
  input  logic [127:0]      i_l2_wr_data,
  output logic              o_l2_wr_ready,
  l2_ddr_port_ctrl_if.master app,
  output logic [31:0]       o_stat_rd_beats,
  output logic [31:0]       o_stat_wr_beats,
  output logic [31:0]       o_stat_stall
);

  localparam int unsigned       CNT_W     = $clog2(BURST_BEATS) + 1;
  localparam logic [2:0]        CMD_RD    = 3'b001;
  localparam logic [2:0]        CMD_WR    = 3'b000;
  localparam logic [ADDR_W-1:0] LOCK_TH   = ADDR_W'(WINDOW_WORDS - BURST_BEATS);
  localparam logic [ADDR_W-1:0] BURST_INC = ADDR_W'(BURST_BEATS);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_BEATS - 1);

  typedef enum logic [2:0] {IDLE, RD_CMD, RD_WAIT, WR_DATA, WR_CMD} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   fetch_q, fetch_d;
  logic [ADDR_W-1:0]   wbase_q, wbase_d;
  logic [CNT_W-1:0]    cmd_cnt_q, cmd_cnt_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic                bus_en_q, bus_en_d;
  logic                app_en_q, app_en_d;
  logic [2:0]          app_cmd_q, app_cmd_d;
  logic [ADDR_W+2:0]   app_addr_q, app_addr_d;
  logic                wren_q, wren_d;
  logic                rd_valid_q, rd_valid_d;
  logic [127:0]        rd_data_q, rd_data_d;
  logic                force_q, force_d;

  logic [ADDR_W-1:0]   occupancy;
  logic [CNT_W-1:0]    cmd_nxt;
  logic [ADDR_W-1:0]   rd_word_nxt;
  logic [ADDR_W-1:0]   wr_word;
  logic                beat_in;

  // Window occupancy wraps with the pointers; lock is decoded straight from registers.
  assign occupancy             = fetch_q - base_q;
  assign o_l2_ddr_operate_lock = occupancy > LOCK_TH;

  assign cmd_nxt     = cmd_cnt_q + CNT_W'(1);
  assign rd_word_nxt = fetch_q + ADDR_W'(cmd_nxt);
  assign wr_word     = wbase_q + ADDR_W'(cmd_cnt_q);
  assign beat_in     = app.app_rd_data_valid && ((state_q == RD_CMD) || (state_q == RD_WAIT));

  assign o_l2_ddr_bus_enable    = bus_en_q;
  assign o_l2_ddr_force_loading = force_q;
  assign o_l2_rd_data           = rd_data_q;
  assign o_l2_rd_valid          = rd_valid_q;
  assign app.app_en             = app_en_q;
  assign app.app_cmd            = app_cmd_q;
  assign app.app_addr           = app_addr_q;
  // Write data flows through from the L2; the beat is consumed when the MIG takes it.
  assign app.app_wdf_wren       = wren_q;
  assign app.app_wdf_end        = wren_q;
  assign app.app_wdf_data       = wren_q ? i_l2_wr_data : '0;
  assign o_l2_wr_ready          = wren_q && app.app_wdf_rdy;

  always_ff @(posedge clk_166M66) begin
    if (mcu_sys_rst) begin
      state_q    <= IDLE;
      base_q     <= '0;
      fetch_q    <= '0;
      wbase_q    <= '0;
      cmd_cnt_q  <= '0;
      beat_cnt_q <= '0;
      bus_en_q   <= 1'b0;
      app_en_q   <= 1'b0;
      app_cmd_q  <= '0;
      app_addr_q <= '0;
      wren_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      force_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      fetch_q    <= fetch_d;
      wbase_q    <= wbase_d;
      cmd_cnt_q  <= cmd_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      bus_en_q   <= bus_en_d;
      app_en_q   <= app_en_d;
      app_cmd_q  <= app_cmd_d;
      app_addr_q <= app_addr_d;
      wren_q     <= wren_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      force_q    <= force_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    fetch_d    = fetch_q;
    wbase_d    = wbase_q;
    cmd_cnt_d  = cmd_cnt_q;
    beat_cnt_d = beat_cnt_q;
    bus_en_d   = bus_en_q;
    app_en_d   = app_en_q;
    app_cmd_d  = app_cmd_q;
    app_addr_d = app_addr_q;
    wren_d     = wren_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    force_d    = 1'b0;

    // Read data is forwarded whenever a read burst is in flight, including during commands.
    if (beat_in) begin
      rd_valid_d = 1'b1;
      rd_data_d  = app.app_rd_data;
      beat_cnt_d = beat_cnt_q + CNT_W'(1);
    end

    // Base never passes fetch on an inc; simultaneous inc/dec cancel.
    if (i_ddr_base_addr_inc && !i_ddr_base_addr_dec && (base_q != fetch_q)) begin
      base_d = base_q + ADDR_W'(1);
    end else if (i_ddr_base_addr_dec && !i_ddr_base_addr_inc) begin
      base_d = base_q - ADDR_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (i_jump_valid) begin
          base_d  = i_jump_addr;
          fetch_d = i_jump_addr;
          force_d = 1'b1;
        end else if (app.init_calib_complete && i_l2_ddr_operate_enable &&
                     (i_l2_ddr_rw || !o_l2_ddr_operate_lock)) begin
          bus_en_d   = 1'b1;
          cmd_cnt_d  = '0;
          beat_cnt_d = '0;
          if (i_l2_ddr_rw) begin
            wbase_d = base_q;
            wren_d  = 1'b1;
            state_d = WR_DATA;
          end else begin
            app_en_d   = 1'b1;
            app_cmd_d  = CMD_RD;
            app_addr_d = {fetch_q, 3'b000};
            state_d    = RD_CMD;
          end
        end
      end

      RD_CMD: begin
        if (app.app_rdy) begin
          if (cmd_cnt_q == LAST_BEAT) begin
            app_en_d = 1'b0;
            state_d  = RD_WAIT;
          end else begin
            cmd_cnt_d  = cmd_nxt;
            app_addr_d = {rd_word_nxt, 3'b000};
          end
        end
      end

      RD_WAIT: begin
        if (beat_in && (beat_cnt_q == LAST_BEAT)) begin
          fetch_d  = fetch_q + BURST_INC;
          bus_en_d = 1'b0;
          state_d  = IDLE;
        end
      end

      // Each write beat is followed by its own command before the next beat is taken.
      WR_DATA: begin
        if (app.app_wdf_rdy) begin
          wren_d     = 1'b0;
          app_en_d   = 1'b1;
          app_cmd_d  = CMD_WR;
          app_addr_d = {wr_word, 3'b000};
          state_d    = WR_CMD;
        end
      end

      WR_CMD: begin
        if (app.app_rdy) begin
          app_en_d = 1'b0;
          if (cmd_cnt_q == LAST_BEAT) begin
            bus_en_d = 1'b0;
            state_d  = IDLE;
          end else begin
            cmd_cnt_d = cmd_nxt;
            wren_d    = 1'b1;
            state_d   = WR_DATA;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

`ifdef L2_DDR_PORT_STATS_EN
  logic [31:0] stat_rd_q, stat_wr_q, stat_stall_q;

  // Saturating event counters.
  always_ff @(posedge clk_166M66) begin
    if (mcu_sys_rst) begin
      stat_rd_q    <= '0;
      stat_wr_q    <= '0;
      stat_stall_q <= '0;
    end else begin
      if (rd_valid_q && (stat_rd_q != 32'hFFFF_FFFF)) begin
        stat_rd_q <= stat_rd_q + 32'd1;
      end
      if (wren_q && app.app_wdf_rdy && (stat_wr_q != 32'hFFFF_FFFF)) begin
        stat_wr_q <= stat_wr_q + 32'd1;
      end
      if (app_en_q && !app.app_rdy && (stat_stall_q != 32'hFFFF_FFFF)) begin
        stat_stall_q <= stat_stall_q + 32'd1;
      end
    end
  end

  assign o_stat_rd_beats = stat_rd_q;
  assign o_stat_wr_beats = stat_wr_q;
  assign o_stat_stall    = stat_stall_q;
`else
  assign o_stat_rd_beats = 32'h0;
  assign o_stat_wr_beats = 32'h0;
  assign o_stat_stall    = 32'h0;
`endif

endmodule
